// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Elaboration-time ceil(log2(v)); loop bound keeps the shift inside int range.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_tick.sv
// Scan prescaler: counts 0..DIV-1 while enabled, tick is high during count DIV-1.
// clr forces the count back to 0 on the next enabled edge.
module scan_tick
  import mux_scan_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == TOP) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TOP);

endmodule

// File: rtl/mux_scan.sv
// N-channel mux with manual select or timed auto-scan; all data outputs registered, 1-cycle latency.
// wrap is decoded from registered state and is high during the cycle whose edge moves the pointer N-1 -> 0.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int W   = 5,
  parameter int N   = 4,
  parameter int DIV = 16,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  cur_sel,
  output logic [N-1:0]   onehot,
  output logic           wrap
);

  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [W-1:0]  dout_q, dout_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          tick;

  scan_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (mode == MODE_MANUAL),
    .tick (tick)
  );

  always_comb begin
    dout_d    = dout_q;
    cur_sel_d = cur_sel_q;
    onehot_d  = onehot_q;
    ptr_d     = ptr_q;
    if (mode == MODE_SCAN) begin
      dout_d    = din[int'(ptr_q) * W +: W];
      cur_sel_d = ptr_q;
      onehot_d  = ONE << ptr_q;
      if (tick) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end else begin
      // Pointer parks at 0 so the next scan entry starts from channel 0.
      ptr_d = '0;
      if (int'(sel) < N) begin
        dout_d    = din[int'(sel) * W +: W];
        cur_sel_d = sel;
        onehot_d  = ONE << sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      cur_sel_q <= '0;
      onehot_q  <= ONE;
      ptr_q     <= '0;
    end else if (en) begin
      dout_q    <= dout_d;
      cur_sel_q <= cur_sel_d;
      onehot_q  <= onehot_d;
      ptr_q     <= ptr_d;
    end
  end

  assign dout    = dout_q;
  assign cur_sel = cur_sel_q;
  assign onehot  = onehot_q;
  assign wrap    = !rst && en && (mode == MODE_SCAN) && tick && (ptr_q == LAST);

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter W, default 5, data width per channel in bits (W >= 1).
REQ-002 Parameter N, default 4, number of input channels (2 <= N <= 16).
REQ-003 Parameter DIV, default 16, clock cycles each channel is held in scan mode (DIV >= 1).
REQ-004 Derived constant SW = clog2(N), select width in bits.
REQ-005 clk  input  1  single clock; all registers update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  clock enable; 0 freezes every register.
REQ-008 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 sel  input  SW  manual channel select, used only when mode = 0.
REQ-010 din  input  N*W  flattened channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-011 dout  output  W  registered selected data.
REQ-012 cur_sel  output  SW  registered index of the channel currently driving dout.
REQ-013 onehot  output  N  registered one-hot decode of cur_sel.
REQ-014 wrap  output  1  single-cycle pulse when the scan pointer wraps from N-1 to 0.

Function
REQ-015 Latency: dout, cur_sel and onehot reflect inputs sampled at edge t, visible after edge t; one cycle, no combinational path from din or sel to any output.
REQ-016 Manual mode (mode=0, en=1): cur_sel <= sel; dout <= din channel sel; prescaler held at 0; wrap = 0.
REQ-017 Manual out-of-range sel (sel >= N, non-power-of-2 N): cur_sel, dout and onehot hold their previous values.
REQ-018 Scan mode (mode=1, en=1): prescaler counts 0..DIV-1; at count DIV-1 the prescaler returns to 0 and the pointer advances by 1; otherwise the pointer holds.
REQ-019 Scan wrap-around: pointer at N-1 advances to 0 and wrap = 1 for exactly that cycle; wrap = 0 on every other cycle.
REQ-020 In scan mode dout <= din channel at the pointer every enabled cycle, so din changes on the active channel propagate with 1-cycle latency.
REQ-021 DIV = 1: the pointer advances every enabled cycle.
REQ-022 Mode 0 -> 1 transition: in the first scan cycle, pointer = 0, prescaler = 0, and dout loads channel 0.
REQ-023 Mode 1 -> 0 transition: manual behaviour (REQ-016) applies on the same edge; the prescaler clears.
REQ-024 en = 0: all registers hold and wrap = 0; en has no effect on rst.
REQ-025 onehot = 1 << cur_sel at all times after reset.

Reset
REQ-026 On rst = 1 at a clock edge: dout = 0, cur_sel = 0, onehot = 1 (bit 0 set), wrap = 0, prescaler = 0, pointer = 0.
REQ-027 rst has priority over en and mode; reset mid-scan abandons the current count, and scanning resumes from channel 0 with a full DIV period.

Structure
REQ-028 A shared package holds the clog2 function and the named constants MODE_MANUAL = 0 and MODE_SCAN = 1.
REQ-029 The prescaler is a separate sub-module, scan_tick (params DIV; ports clk, rst, en, clr, tick), where tick is high during count DIV-1.
REQ-030 Channel extraction uses indexed part-select on din; no per-channel hand-written case arms.

Verification
REQ-031 W=5, N=4: rst for 2 cycles -> dout=0, cur_sel=0, onehot=4'b0001, wrap=0.
REQ-032 Manual, channels 0..3 = 5'h01, 5'h0A, 5'h15, 5'h1F; sel 0,1,2,3 on consecutive cycles -> dout 01, 0A, 15, 1F, each one cycle later.
REQ-033 Scan, DIV=4, N=4, 20 cycles -> cur_sel holds 4 cycles each in the order 0,1,2,3,0; wrap high exactly once, on the 3->0 step.
REQ-034 Scan, en held low 3 cycles mid-period -> cur_sel, dout and prescaler frozen; the period completes 3 cycles late.
REQ-035 Scan at pointer 2, rst asserted for 1 cycle -> cur_sel=0, dout=0; first advance occurs DIV cycles after rst deasserts.
REQ-036 N=3, manual sel=3 after sel=1 -> dout and cur_sel keep their channel-1 values, onehot=3'b010.
